// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Holds the data memory, performs word/halfword/byte loads and stores with
// alignment and range checking, selects the write-back value and registers
// the result into the MEM/WB pipeline register.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous active-low reset (clears outputs and memory)
//   ResM       - ALU result / byte address
//   MemWDM     - store data
//   PC4M       - PC+4 of the instruction
//   MemtoRegM  - write-back select: 00 ALU, 01 load, 10 link, 11 zero
//   RegWriteM  - register write enable
//   MemWriteM  - store enable
//   resOpM     - access width: 00 word, 01 half, 10 byte, 11 word
//   LoadSignM  - sign-extend narrow loads when 1
//   A3M        - destination register
//   WDW        - registered write-back data
//   A3W        - registered destination register
//   RegWriteW  - registered, gated write enable
//   PC4W       - registered PC+4
//   ExcW       - registered fault: 00 none, 01 misaligned, 10 out of range
module mem_stage #(
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned AW       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ResM,
    input  logic [31:0] MemWDM,
    input  logic [31:0] PC4M,
    input  logic [1:0]  MemtoRegM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  resOpM,
    input  logic        LoadSignM,
    input  logic [4:0]  A3M,
    output logic [31:0] WDW,
    output logic [4:0]  A3W,
    output logic        RegWriteW,
    output logic [31:0] PC4W,
    output logic [1:0]  ExcW
);

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;

    logic [31:0]   mem [DM_WORDS];

    logic [AW-1:0] idx;
    logic          hi_nz;
    logic          idx_oor;
    logic          oor;
    logic          is_half;
    logic          is_byte;
    logic          is_word;
    logic          misaligned;
    logic          is_mem;
    logic [1:0]    exc;
    logic          fault;
    logic          store_en;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic [31:0]   wb_data;
    logic [31:0]   wd_next;
    logic          rw_next;

    assign idx   = ResM[AW+1:2];
    assign hi_nz = |ResM[31:AW+2];

    // Index range check only exists when the memory does not fill the index space
    if (DM_WORDS < (32'd1 << AW)) begin : g_partial
        assign idx_oor = (idx >= AW'(DM_WORDS));
    end else begin : g_full
        assign idx_oor = 1'b0;
    end

    assign oor     = hi_nz | idx_oor;
    assign is_half = (resOpM == 2'b01);
    assign is_byte = (resOpM == 2'b10);
    assign is_word = !is_half && !is_byte;

    assign misaligned = (is_word && (ResM[1:0] != 2'b00)) || (is_half && ResM[0]);
    assign is_mem     = MemWriteM || (MemtoRegM == 2'b01);

    // Misalignment outranks out-of-range; only memory instructions can fault
    always_comb begin
        exc = EXC_NONE;
        if (is_mem) begin
            if (misaligned) begin
                exc = EXC_ALIGN;
            end else if (oor) begin
                exc = EXC_RANGE;
            end
        end
    end

    assign fault    = (exc != EXC_NONE);
    assign store_en = MemWriteM && !fault;
    assign rd_word  = oor ? 32'd0 : mem[idx];

    // Little-endian lane extraction and extension
    always_comb begin
        ld_byte = rd_word[7:0];
        case (ResM[1:0])
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = ResM[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = rd_word;
        if (is_byte) begin
            ld_data = LoadSignM ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
        end else if (is_half) begin
            ld_data = LoadSignM ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
        end
        if (fault) begin
            ld_data = 32'd0;
        end
    end

    // Merge narrow store data into the addressed word
    always_comb begin
        wr_word = rd_word;
        if (is_byte) begin
            case (ResM[1:0])
                2'd0: wr_word[7:0]   = MemWDM[7:0];
                2'd1: wr_word[15:8]  = MemWDM[7:0];
                2'd2: wr_word[23:16] = MemWDM[7:0];
                2'd3: wr_word[31:24] = MemWDM[7:0];
                default: wr_word[7:0] = MemWDM[7:0];
            endcase
        end else if (is_half) begin
            if (ResM[1]) begin
                wr_word[31:16] = MemWDM[15:0];
            end else begin
                wr_word[15:0] = MemWDM[15:0];
            end
        end else begin
            wr_word = MemWDM;
        end
    end

    // Write-back select with r0 suppression
    always_comb begin
        wb_data = 32'd0;
        case (MemtoRegM)
            2'b00: wb_data = ResM;
            2'b01: wb_data = ld_data;
            2'b10: wb_data = PC4M + 32'd4;
            2'b11: wb_data = 32'd0;
            default: wb_data = 32'd0;
        endcase
        wd_next = (A3M == 5'd0) ? 32'd0 : wb_data;
        rw_next = RegWriteM && !fault && (A3M != 5'd0);
    end

    // Data memory: cleared by reset, written only at the edge (no bypass)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DM_WORDS); i++) begin
                mem[i] <= 32'd0;
            end
        end else if (store_en) begin
            mem[idx] <= wr_word;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WDW       <= 32'd0;
            A3W       <= 5'd0;
            RegWriteW <= 1'b0;
            PC4W      <= 32'd0;
            ExcW      <= EXC_NONE;
        end else begin
            WDW       <= wd_next;
            A3W       <= A3M;
            RegWriteW <= rw_next;
            PC4W      <= PC4M;
            ExcW      <= exc;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. A byte-addressed reference
// memory predicts each instruction's MEM/WB result; predictions are queued when
// the instruction is driven and compared after the capturing clock edge.
module tb_mem_stage;

    localparam int unsigned DM_WORDS = 1024;
    localparam int unsigned AW       = 10;
    localparam int unsigned NBYTES   = DM_WORDS * 4;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  a3;
        logic        rw;
        logic [31:0] pc4;
        logic [1:0]  exc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] ResM;
    logic [31:0] MemWDM;
    logic [31:0] PC4M;
    logic [1:0]  MemtoRegM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  resOpM;
    logic        LoadSignM;
    logic [4:0]  A3M;
    logic [31:0] WDW;
    logic [4:0]  A3W;
    logic        RegWriteW;
    logic [31:0] PC4W;
    logic [1:0]  ExcW;

    logic [7:0]  ref_mem [NBYTES];
    exp_t        sb [$];
    int          n_tests;
    int          n_fail;

    mem_stage #(.DM_WORDS(DM_WORDS), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ResM      (ResM),
        .MemWDM    (MemWDM),
        .PC4M      (PC4M),
        .MemtoRegM (MemtoRegM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .resOpM    (resOpM),
        .LoadSignM (LoadSignM),
        .A3M       (A3M),
        .WDW       (WDW),
        .A3W       (A3W),
        .RegWriteW (RegWriteW),
        .PC4W      (PC4W),
        .ExcW      (ExcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'd0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".WDW"},       WDW,              32'd0);
        check({tag, ".A3W"},       {27'd0, A3W},     32'd0);
        check({tag, ".RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
        check({tag, ".PC4W"},      PC4W,             32'd0);
        check({tag, ".ExcW"},      {30'd0, ExcW},    32'd0);
    endtask

    // Reference prediction built on byte storage; updates the reference on stores
    function automatic exp_t predict(input logic [31:0] res, input logic [31:0] sd,
                                     input logic [31:0] pc4, input logic [1:0] mtr,
                                     input logic rw, input logic mw, input logic [1:0] op,
                                     input logic sgn, input logic [4:0] a3);
        exp_t        e;
        int          nb;
        logic        mis;
        logic        out_range;
        logic [31:0] raw;
        logic [31:0] ld;
        logic [31:0] wb;
        int          base;
        nb        = (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 4;
        mis       = (res % nb) != 0;
        out_range = (res / 4) >= DM_WORDS;
        e.exc     = 2'b00;
        if (mw || mtr == 2'b01) begin
            if (mis) e.exc = 2'b01;
            else if (out_range) e.exc = 2'b10;
        end
        raw = 32'd0;
        if (!out_range && e.exc == 2'b00) begin
            base = int'(res);
            for (int k = nb - 1; k >= 0; k--) raw = (raw << 8) | 32'(ref_mem[base + k]);
        end
        ld = raw;
        if (sgn && nb == 1 && raw[7])  ld = raw | 32'hFFFF_FF00;
        if (sgn && nb == 2 && raw[15]) ld = raw | 32'hFFFF_0000;
        case (mtr)
            2'b00:   wb = res;
            2'b01:   wb = ld;
            2'b10:   wb = pc4 + 32'd4;
            default: wb = 32'd0;
        endcase
        e.wd  = (a3 == 5'd0) ? 32'd0 : wb;
        e.rw  = rw && (e.exc == 2'b00) && (a3 != 5'd0);
        e.a3  = a3;
        e.pc4 = pc4;
        if (mw && e.exc == 2'b00) begin
            base = int'(res);
            for (int k = 0; k < nb; k++) ref_mem[base + k] = sd[8*k +: 8];
        end
        return e;
    endfunction

    // Drive one instruction, queue its prediction, compare after the capturing edge
    task automatic issue(input string tag, input logic [31:0] res, input logic [31:0] sd,
                         input logic [31:0] pc4, input logic [1:0] mtr, input logic rw,
                         input logic mw, input logic [1:0] op, input logic sgn,
                         input logic [4:0] a3);
        exp_t e;
        ResM = res; MemWDM = sd; PC4M = pc4; MemtoRegM = mtr;
        RegWriteM = rw; MemWriteM = mw; resOpM = op; LoadSignM = sgn; A3M = a3;
        sb.push_back(predict(res, sd, pc4, mtr, rw, mw, op, sgn, a3));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".WDW"},       WDW,                e.wd);
            check({tag, ".A3W"},       {27'd0, A3W},       {27'd0, e.a3});
            check({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, e.rw});
            check({tag, ".PC4W"},      PC4W,               e.pc4);
            check({tag, ".ExcW"},      {30'd0, ExcW},      {30'd0, e.exc});
        end
    endtask

    task automatic bubble(input string tag);
        issue(tag, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_data;
        logic [1:0]  r_op;
        logic [1:0]  r_mtr;
        n_tests = 0;
        n_fail  = 0;
        clear_ref();
        ResM = 0; MemWDM = 0; PC4M = 0; MemtoRegM = 0;
        RegWriteM = 0; MemWriteM = 0; resOpM = 0; LoadSignM = 0; A3M = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_outputs_zero("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Store then read back, then reset mid-cycle
        issue("sw10", 32'h10, 32'h1234_5678, 32'h100, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0);
        issue("lw10", 32'h10, 32'd0, 32'h104, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd2);
        check("lw10.value", WDW, 32'h1234_5678);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        clear_ref();
        // Store presented while reset is held must be discarded
        ResM = 32'h10; MemWDM = 32'hDEAD_BEEF; MemWriteM = 1'b1; A3M = 5'd3;
        RegWriteM = 1'b1; MemtoRegM = 2'b00; resOpM = 2'b00; PC4M = 32'h200;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        reset = 1'b1;
        issue("lw10_rst", 32'h10, 32'd0, 32'h108, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd2);
        check("lw10_rst.value", WDW, 32'd0);

        // Byte merge
        issue("sw20", 32'h20, 32'hAABB_CCDD, 32'h300, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0);
        issue("sb21", 32'h21, 32'h0000_0011, 32'h304, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0);
        issue("lw20", 32'h20, 32'd0, 32'h308, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd4);
        check("merge.value", WDW, 32'hAABB_11DD);

        // Load extension
        issue("sw20b", 32'h20, 32'h80FF_7F01, 32'h400, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0);
        issue("lb22", 32'h22, 32'd0, 32'h404, 2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 5'd5);
        check("lb22.value", WDW, 32'hFFFF_FFFF);
        issue("lhu22", 32'h22, 32'd0, 32'h408, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 5'd5);
        check("lhu22.value", WDW, 32'h0000_80FF);
        issue("lh20", 32'h20, 32'd0, 32'h40C, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 5'd5);
        check("lh20.value", WDW, 32'h0000_7F01);

        // Misalignment
        issue("sw22", 32'h22, 32'hCAFE_BABE, 32'h500, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'd5);
        check("sw22.exc", {30'd0, ExcW}, 32'd1);
        issue("lh23", 32'h23, 32'd0, 32'h504, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 5'd6);
        check("lh23.exc", {30'd0, ExcW}, 32'd1);
        check("lh23.rw", {31'd0, RegWriteW}, 32'd0);
        issue("lw20c", 32'h20, 32'd0, 32'h508, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7);
        check("lw20c.value", WDW, 32'h80FF_7F01);

        // Out of range
        issue("lw1000", 32'h0000_1000, 32'd0, 32'h600, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7);
        check("oor.exc", {30'd0, ExcW}, 32'd2);
        check("oor.wd", WDW, 32'd0);

        // Link and r0
        issue("link", 32'h0, 32'd0, 32'h0000_3004, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 5'd31);
        check("link.value", WDW, 32'h0000_3008);
        issue("r0", 32'h55, 32'd0, 32'h700, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0);
        check("r0.rw", {31'd0, RegWriteW}, 32'd0);
        issue("alu", 32'h55, 32'd0, 32'h704, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'd9);
        issue("zero_sel", 32'h77, 32'd0, 32'h708, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 5'd9);
        bubble("bubble");

        // Back-to-back halfword and byte stores accumulate in order
        issue("sh40u", 32'h42, 32'h0000_BEEF, 32'h800, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0);
        issue("sh40l", 32'h40, 32'h0000_1234, 32'h804, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0);
        issue("sb43",  32'h43, 32'h0000_00A5, 32'h808, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0);
        issue("lw40",  32'h40, 32'd0, 32'h80C, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd8);
        check("lw40.value", WDW, 32'hA5EF_1234);
        issue("lw_top", 32'hFFC, 32'd0, 32'h810, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 5'd8);

        // Random mix over a small window plus occasional far addresses
        for (int i = 0; i < 60; i++) begin
            r_addr = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 63));
            r_data = $urandom();
            r_op   = 2'($urandom_range(0, 3));
            r_mtr  = 2'($urandom_range(0, 3));
            issue("rnd", r_addr, r_data, $urandom(), r_mtr, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r_op, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)));
        end
        for (int a = 0; a < 64; a += 4) begin
            issue("sweep", 32'(a), 32'd0, 32'h900, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 5'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its M-suffixed outputs. It holds the data memory, performs word, halfword and byte stores and loads with alignment checking, and selects the write-back value. It also contains the MEM/WB pipeline register that feeds the register-file write port.

## Interface
Parameters:
- DM_WORDS, 1024 — data-memory depth in 32-bit words.
- AW, 10 — word-index width; the index is ResM[AW+1:2], and DM_WORDS ≤ 2^AW.

Ports:
- clk  in  1  — single clock; all state updates on its rising edge.
- reset  in  1  — asynchronous, active-low reset.
- ResM  in  32  — ALU result; byte address for loads and stores.
- MemWDM  in  32  — store data; the low byte or halfword is used for narrow stores.
- PC4M  in  32  — PC+4 of the instruction.
- MemtoRegM  in  2  — write-back select: 00 ALU, 01 load, 10 link (PC+8), 11 zero.
- RegWriteM  in  1  — register write enable.
- MemWriteM  in  1  — store enable.
- resOpM  in  2  — access width: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- LoadSignM  in  1  — 1 sign-extends narrow loads, 0 zero-extends them.
- A3M  in  5  — destination register.
- WDW  out  32  — registered write-back data.
- A3W  out  5  — registered destination register.
- RegWriteW  out  1  — registered write enable, after gating.
- PC4W  out  32  — registered PC+4.
- ExcW  out  2  — registered fault: 00 none, 01 misaligned, 10 address out of range.

## Operation
- Alignment check:
  - Misaligned when a word access has ResM[1:0]≠0, or a halfword access has ResM[0]=1.
  - Byte accesses are never misaligned.
- Range check: out of range when ResM[31:AW+2]≠0, or when the word index is ≥ DM_WORDS.
- Fault priority and effect:
  - Misalignment outranks out-of-range when both apply.
  - A fault applies only when the instruction is a store or a load (MemWriteM=1 or MemtoRegM=01).
  - On a fault, the store is suppressed, the load data is forced to 0, and RegWriteW is forced to 0.
- Stores:
  - A store happens on the clock edge when MemWriteM=1 and there is no fault.
  - Byte order is little-endian: lane 0 is bits 7:0, selected by ResM[1:0].
  - Byte store: MemWDM[7:0] replaces one lane; the other three bytes are unchanged.
  - Halfword store: MemWDM[15:0] replaces bits 15:0 when ResM[1]=0, or bits 31:16 when ResM[1]=1.
  - Word store: all 32 bits are written.
- Loads:
  - Reads are combinational from the currently addressed word.
  - The lane is extracted using the same lane mapping as stores.
  - The result is extended to 32 bits as LoadSignM selects; word loads are not extended.
- Write-back select: 00 gives ResM, 01 gives the load data, 10 gives PC4M+4 (modulo 2^32), 11 gives 0.
- MEM/WB register: WDW, A3W, RegWriteW, PC4W and ExcW are loaded every clock edge.
- Destination r0: when A3M=0, the stage forces RegWriteW to 0 and WDW to 0.

## Timing
- Reset:
  - Asserting reset (low) immediately clears all five outputs to 0, independent of clk.
  - It also clears every data-memory word to 0.
  - While reset is low, no store takes effect.
- Reset release: the first rising edge after reset goes high captures live inputs.
- Latency:
  - A store commits at edge t.
  - A load issued in the cycle after t returns the new data.
  - A load's write-back data appears on WDW one edge after it is presented.
- Storage timing: a store and a read of the same word in one cycle cannot come from one instruction. The memory therefore updates only at the edge, with no internal bypass.
- Back-to-back: stores in consecutive cycles to the same word apply in order, so byte merges accumulate.
- Reset mid-operation: a store whose edge coincides with reset asserted is discarded.
- Stalls and bubbles: this block has no stall input. The upstream register inserts bubbles as zero controls, which produce WDW=0 and RegWriteW=0.

## Test plan
- Reset behaviour:
  - Stimulus: drive reset low mid-cycle after a prior word store of 0x12345678 at address 0x10.
  - Required: all outputs go to 0 at once.
  - Required: after release, a word load from 0x10 gives WDW=0.
- Byte merge:
  - Stimulus: word store 0xAABBCCDD at 0x20, then byte store 0x11 at 0x21, then a word load from 0x20.
  - Required: WDW=0xAABB11DD.
- Load extension:
  - Stimulus: memory at 0x20 holds 0x80FF7F01.
  - Required: signed byte load at 0x22 gives 0xFFFFFFFF.
  - Required: unsigned halfword load at 0x22 gives 0x000080FF.
  - Required: signed halfword load at 0x20 gives 0x00007F01.
- Misalignment:
  - Stimulus: word store at 0x22, then a halfword load at 0x23.
  - Required: ExcW=01 and RegWriteW=0 for both.
  - Required: the memory word at 0x20 is unchanged.
- Out of range:
  - Stimulus: word load at 0x00001000 with DM_WORDS=1024.
  - Required: ExcW=10, WDW=0, RegWriteW=0.
- Write-back select and r0:
  - Stimulus: link with PC4M=0x00003004 and A3M=31.
  - Required: WDW=0x00003008.
  - Stimulus: ALU result 0x55 with A3M=0.
  - Required: RegWriteW=0 and WDW=0.
